// File: rtl/sub_serial_16.sv
// Multi-cycle unsigned subtractor: diff = a - b - b_in, one DIGIT-bit slice per clock, LSB first.
// Define SUB_SERIAL_OVF_EN to add the registered signed-overflow output ovf.
module sub_serial_16 #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
`ifdef SUB_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] work_q;
  logic             borrow_q;

  int               slice_lo;
  logic [DIGIT-1:0] a_sl;
  logic [DIGIT-1:0] b_sl;
  logic [DIGIT-1:0] d_sl;
  logic             carry;
  logic             msb_cin;
  logic             bo;
  logic [WIDTH-1:0] work_d;

  // Slice datapath: a + ~b + ~borrow, borrow out is the inverted carry.
  always_comb begin
    slice_lo = int'(cnt_q) * int'(DIGIT);
    a_sl     = a_q[slice_lo +: DIGIT];
    b_sl     = b_q[slice_lo +: DIGIT];
    d_sl     = '0;
    carry    = ~borrow_q;
    msb_cin  = carry;
    for (int i = 0; i < int'(DIGIT); i++) begin
      msb_cin = carry;
      d_sl[i] = a_sl[i] ^ ~b_sl[i] ^ carry;
      carry   = (a_sl[i] & ~b_sl[i]) | (a_sl[i] & carry) | (~b_sl[i] & carry);
    end
    bo     = ~carry;
    work_d = work_q;
    work_d[slice_lo +: DIGIT] = d_sl;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      borrow_q <= 1'b0;
      diff     <= '0;
      b_out    <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
      ovf      <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= b_in;
            cnt_q    <= '0;
            busy     <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          work_q   <= work_d;
          borrow_q <= bo;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            // Last slice goes straight into diff; working register bypassed.
            diff    <= work_d;
            b_out   <= bo;
`ifdef SUB_SERIAL_OVF_EN
            ovf     <= msb_cin ^ carry;
`endif
            cnt_q   <= '0;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_serial_16.sv
// Directed self-checking bench for sub_serial_16 (ovf checks when SUB_SERIAL_OVF_EN is defined).
module tb_sub_serial_16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        b_in;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        b_out;
`ifdef SUB_SERIAL_OVF_EN
  logic        ovf;
`endif

  int unsigned tests;
  int unsigned fails;
  logic [15:0] last_diff;

  sub_serial_16 #(
    .WIDTH(16),
    .DIGIT(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .b_in (b_in),
    .busy (busy),
    .done (done),
    .diff (diff),
    .b_out(b_out)
`ifdef SUB_SERIAL_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge with the DUT idle.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic bi, input logic [15:0] ed, input logic eb, input logic eo);
    a     = av;
    b     = bv;
    b_in  = bi;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = ~av;
    b     = ~bv;
    b_in  = ~bi;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
      check({tag, "_done_run"}, {31'd0, done}, 32'd0);
      if (i == 2) check({tag, "_diff_hold"}, {16'd0, diff}, {16'd0, last_diff});
      tick();
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    check({tag, "_diff"}, {16'd0, diff}, {16'd0, ed});
    check({tag, "_bout"}, {31'd0, b_out}, {31'd0, eb});
`ifdef SUB_SERIAL_OVF_EN
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
`else
    if (eo !== eo) check({tag, "_ovf_x"}, 32'd0, 32'd1);
`endif
    tick();
    check({tag, "_done_clr"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_clr"}, {31'd0, busy}, 32'd0);
    last_diff = ed;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    last_diff = 16'h0000;
    rst       = 1'b1;
    start     = 1'b0;
    a         = 16'h0;
    b         = 16'h0;
    b_in      = 1'b0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {16'd0, diff}, 32'd0);
    check("rst_bout", {31'd0, b_out}, 32'd0);
    rst = 1'b0;
    tick();

    run_op("basic", 16'h00bd, 16'h00ab, 1'b0, 16'h0012, 1'b0, 1'b0);
    run_op("neg", 16'h00ab, 16'h00bd, 1'b0, 16'hffee, 1'b1, 1'b0);
    run_op("ripple", 16'h1000, 16'h0001, 1'b1, 16'h0ffe, 1'b0, 1'b0);
    run_op("zero_bin", 16'h0000, 16'h0000, 1'b1, 16'hffff, 1'b1, 1'b0);

    // Start pulses while busy must be ignored.
    a = 16'h00bd; b = 16'h00ab; b_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 16'hffff; b = 16'h0000; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("ign_done", {31'd0, done}, 32'd1);
    check("ign_diff", {16'd0, diff}, 32'h0012);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_idle", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("ign_no_done", {31'd0, done}, 32'd0);
      check("ign_no_busy", {31'd0, busy}, 32'd0);
      tick();
    end
    check("ign_diff_keep", {16'd0, diff}, 32'h0012);
    last_diff = 16'h0012;

    // Asynchronous reset in the second RUN cycle aborts the operation.
    a = 16'h5555; b = 16'h1111; b_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_diff", {16'd0, diff}, 32'd0);
    check("mid_rst_bout", {31'd0, b_out}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_done", {31'd0, done}, 32'd0);
    last_diff = 16'h0000;
    run_op("after_rst", 16'h5555, 16'h1111, 1'b0, 16'h4444, 1'b0, 1'b0);

    run_op("ovf_min", 16'h8000, 16'h0001, 1'b0, 16'h7fff, 1'b0, 1'b1);
    run_op("ovf_max", 16'h7fff, 16'hffff, 1'b0, 16'h8000, 1'b1, 1'b1);
    run_op("no_ovf", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);

    // start held high: re-accepted as soon as the block is back in IDLE.
    a = 16'h0003; b = 16'h0001; b_in = 1'b0; start = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    tick();
    check("hold_done1", {31'd0, done}, 32'd1);
    check("hold_diff1", {16'd0, diff}, 32'h0002);
    tick();
    check("hold_idle", {31'd0, busy}, 32'd0);
    a = 16'h0010; b = 16'h0001;
    tick();
    check("hold_reacc", {31'd0, busy}, 32'd1);
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("hold_done2", {31'd0, done}, 32'd1);
    check("hold_diff2", {16'd0, diff}, 32'h000f);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
